data_mem_bank: RTL and testbench

- Parametrised successor to the single-port point-cloud data_mem.
- Simple dual-port synchronous RAM: one write port and one read port, both usable in the same cycle.
- Write data is split into NUM_LANES lanes with a per-lane write mask. Registered read has a valid flag and write-first forwarding.
- A built-in clear engine zeroes the whole array after reset or on request. Point-cloud buffers are reused frame to frame, so this avoids per-frame software clears.

---
 rtl/data_mem_pkg.sv | 33 +++
 rtl/data_mem_bank_if.sv | 29 ++
 rtl/data_mem_clear_ctrl.sv | 47 ++++
 rtl/data_mem_bank.sv | 87 ++++++++
 tb/tb_data_mem_bank.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the data_mem_bank dual-port RAM slice.
package data_mem_pkg;

    typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} mem_state_e;

    localparam int unsigned MaxLanes = 32;
    localparam int unsigned MaxWordW = 1024;

    function automatic int unsigned memDepth(input int unsigned addrWidth);
        return 32'd1 << addrWidth;
    endfunction

    // Lanes whose mask bit is set take newWord; the rest keep oldWord.
    function automatic logic [MaxWordW-1:0] laneMerge(
        input logic [MaxWordW-1:0] oldWord,
        input logic [MaxWordW-1:0] newWord,
        input logic [MaxLanes-1:0] mask,
        input int unsigned         laneWidth
    );
        logic [MaxWordW-1:0] laneOnes;
        logic [MaxWordW-1:0] bitMask;
        logic [MaxLanes-1:0] m;
        laneOnes = ~({MaxWordW{1'b1}} << laneWidth);
        bitMask  = '0;
        m        = mask;
        for (int unsigned l = 0; l < MaxLanes; l++) begin
            if (m[0]) bitMask = bitMask | (laneOnes << (l * laneWidth));
            m = m >> 1;
        end
        return (oldWord & ~bitMask) | (newWord & bitMask);
    endfunction

endpackage

// File: rtl/data_mem_bank_if.sv
// Write/read/clear port bundle of data_mem_bank; master drives requests, slave is the RAM.
interface data_mem_bank_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_LANES  = 1
) ();
    localparam int unsigned W = DATA_WIDTH * NUM_LANES;

    logic                  clr;
    logic                  wEn;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [W-1:0]          data;
    logic [NUM_LANES-1:0]  w_mask;
    logic                  rEn;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [W-1:0]          mem_out;
    logic                  rd_valid;
    logic                  busy;

    modport master (
        output clr, wEn, w_addr, data, w_mask, rEn, r_addr,
        input  mem_out, rd_valid, busy
    );

    modport slave (
        input  clr, wEn, w_addr, data, w_mask, rEn, r_addr,
        output mem_out, rd_valid, busy
    );
endinterface

// File: rtl/data_mem_clear_ctrl.sv
// Clear sweep controller: walks every address once after reset or a clr pulse.
module data_mem_clear_ctrl
    import data_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    output logic                  busy,
    output logic                  clr_we,
    output logic [ADDR_WIDTH-1:0] clr_addr
);
    localparam logic StIdle  = IDLE;
    localparam logic StClear = CLEAR;

    logic                  stateQ, stateD;
    logic [ADDR_WIDTH-1:0] cntQ, cntD;

    always_comb begin
        stateD = stateQ;
        cntD   = cntQ;
        if (clr) begin
            stateD = StClear;
            cntD   = '0;
        end else if (stateQ == StClear) begin
            cntD = cntQ + 1'b1;
            // Leave on the edge that clears the last (all-ones) address.
            if (&cntQ) stateD = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ <= StClear;
            cntQ   <= '0;
        end else begin
            stateQ <= stateD;
            cntQ   <= cntD;
        end
    end

    assign busy     = (stateQ == StClear);
    assign clr_we   = busy;
    assign clr_addr = cntQ;

endmodule

// File: rtl/data_mem_bank.sv
// Simple dual-port lane-masked RAM with write-first forwarding and a self-clearing sweep.
module data_mem_bank
    import data_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned NUM_LANES  = 1
) (
    input logic            clk,
    input logic            rst,
    data_mem_bank_if.slave bus
);
    localparam int unsigned W     = DATA_WIDTH * NUM_LANES;
    localparam int unsigned DEPTH = memDepth(ADDR_WIDTH);

    function automatic logic [W-1:0] mergeWord(
        input logic [W-1:0]         oldWord,
        input logic [W-1:0]         newWord,
        input logic [NUM_LANES-1:0] mask
    );
        logic [MaxWordW-1:0] wide;
        wide = laneMerge(MaxWordW'(oldWord), MaxWordW'(newWord), MaxLanes'(mask), DATA_WIDTH);
        return wide[W-1:0];
    endfunction

    logic                  busy, clrWe;
    logic [ADDR_WIDTH-1:0] clrAddr;

    data_mem_clear_ctrl #(
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_clear_ctrl (
        .clk     (clk),
        .rst     (rst),
        .clr     (bus.clr),
        .busy    (busy),
        .clr_we  (clrWe),
        .clr_addr(clrAddr)
    );

    logic [W-1:0]          mem [DEPTH];
    logic                  userWr, userRd, wrEn;
    logic [ADDR_WIDTH-1:0] wrAddr;
    logic [W-1:0]          wrData, rdWord;
    logic [NUM_LANES-1:0]  wrMask;
    logic [W-1:0]          memOutQ;
    logic                  rdValidQ;

    always_comb begin
        // A clr pulse in the same cycle cancels any user access.
        userWr = !rst && !busy && !bus.clr && bus.wEn && (|bus.w_mask);
        userRd = !busy && !bus.clr && bus.rEn;
        if (clrWe) begin
            wrEn   = !rst;
            wrAddr = clrAddr;
            wrData = '0;
            wrMask = '1;
        end else begin
            wrEn   = userWr;
            wrAddr = bus.w_addr;
            wrData = bus.data;
            wrMask = bus.w_mask;
        end
        rdWord = mem[bus.r_addr];
        if (userWr && (bus.w_addr == bus.r_addr)) begin
            rdWord = mergeWord(rdWord, bus.data, bus.w_mask);
        end
    end

    always_ff @(posedge clk) begin
        if (wrEn) mem[wrAddr] <= mergeWord(mem[wrAddr], wrData, wrMask);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memOutQ  <= '0;
            rdValidQ <= 1'b0;
        end else begin
            rdValidQ <= userRd;
            if (userRd) memOutQ <= rdWord;
        end
    end

    assign bus.mem_out  = memOutQ;
    assign bus.rd_valid = rdValidQ;
    assign bus.busy     = busy;

endmodule

// File: tb/tb_data_mem_bank.sv
// Bench for data_mem_bank: directed vectors, clear/reset sequences and random traffic vs a model.
module tb_data_mem_bank;
    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned NL    = 4;
    localparam int unsigned W     = DW * NL;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_mem_bank_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LANES(NL)) bus ();

    data_mem_bank #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .NUM_LANES (NL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    // Reference: plain word array, writes applied before the read of the same edge.
    logic [W-1:0] mm [DEPTH];
    bit           mBusy  = 1'b1;
    logic [8:0]   mPos   = '0;
    bit           mValid = 1'b0;
    logic [W-1:0] mOut   = '0;

    typedef struct {
        bit           wEn;
        logic [7:0]   wa;
        logic [31:0]  d;
        logic [3:0]   m;
        bit           rEn;
        logic [7:0]   ra;
        bit           chk;
        bit           ev;
        logic [31:0]  eo;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelEdge();
        if (rst) begin
            mBusy  = 1'b1;
            mPos   = '0;
            mValid = 1'b0;
            mOut   = '0;
        end else if (mBusy) begin
            mm[mPos[7:0]] = '0;
            mPos          = mPos + 9'd1;
            mValid        = 1'b0;
            if (bus.clr) mPos = '0;
            else if (mPos == 9'd256) mBusy = 1'b0;
        end else if (bus.clr) begin
            mBusy  = 1'b1;
            mPos   = '0;
            mValid = 1'b0;
        end else begin
            if (bus.wEn) begin
                for (int l = 0; l < NL; l++) begin
                    if (bus.w_mask[l]) mm[bus.w_addr][l*DW +: DW] = bus.data[l*DW +: DW];
                end
            end
            mValid = bus.rEn;
            if (bus.rEn) mOut = mm[bus.r_addr];
        end
    endtask

    task automatic tick();
        modelEdge();
        @(posedge clk);
        #1;
        chk("cyc_busy", 32'(bus.busy), 32'(mBusy));
        chk("cyc_valid", 32'(bus.rd_valid), 32'(mValid));
        chk("cyc_out", bus.mem_out, mOut);
    endtask

    task automatic idleIn();
        bus.clr    = 1'b0;
        bus.wEn    = 1'b0;
        bus.w_addr = '0;
        bus.data   = '0;
        bus.w_mask = '0;
        bus.rEn    = 1'b0;
        bus.r_addr = '0;
    endtask

    task automatic readAddr(input string name, input logic [7:0] a, input logic [31:0] exp);
        bus.wEn    = 1'b0;
        bus.rEn    = 1'b1;
        bus.r_addr = a;
        tick();
        chk({name, "_valid"}, 32'(bus.rd_valid), 32'd1);
        chk({name, "_out"}, bus.mem_out, exp);
        bus.rEn = 1'b0;
    endtask

    // Counts edges until busy drops while rEn is held, checking rd_valid stays low.
    task automatic sweepLen(input string name);
        int n;
        n       = 0;
        bus.rEn = 1'b1;
        while (bus.busy === 1'b1 && n < 1000) begin
            tick();
            n++;
            chk({name, "_valid"}, 32'(bus.rd_valid), 32'd0);
        end
        bus.rEn = 1'b0;
        chk({name, "_len"}, 32'(n), 32'd256);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        vecs[0]  = '{1'b1, 8'd0, 32'd32,        4'hF, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0};
        vecs[1]  = '{1'b1, 8'd1, 32'd33,        4'hF, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0};
        vecs[2]  = '{1'b1, 8'd2, 32'd34,        4'hF, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0};
        vecs[3]  = '{1'b0, 8'd0, 32'd0,         4'h0, 1'b1, 8'd1, 1'b1, 1'b1, 32'd33};
        vecs[4]  = '{1'b0, 8'd0, 32'd0,         4'h0, 1'b0, 8'd0, 1'b1, 1'b0, 32'd33};
        vecs[5]  = '{1'b1, 8'd5, 32'hAABBCCDD,  4'hF, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0};
        vecs[6]  = '{1'b1, 8'd5, 32'h11223344,  4'h5, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0};
        vecs[7]  = '{1'b0, 8'd0, 32'd0,         4'h0, 1'b1, 8'd5, 1'b1, 1'b1, 32'hAA22CC44};
        vecs[8]  = '{1'b1, 8'd7, 32'h01020304,  4'hF, 1'b0, 8'd0, 1'b0, 1'b0, 32'd0};
        vecs[9]  = '{1'b1, 8'd7, 32'hFFFFFFFF,  4'h3, 1'b1, 8'd7, 1'b1, 1'b1, 32'h0102FFFF};
        vecs[10] = '{1'b0, 8'd0, 32'd0,         4'h0, 1'b1, 8'd7, 1'b1, 1'b1, 32'h0102FFFF};
        vecs[11] = '{1'b1, 8'd8, 32'hDEADBEEF,  4'hF, 1'b1, 8'd9, 1'b1, 1'b1, 32'd0};
        vecs[12] = '{1'b1, 8'd9, 32'h12345678,  4'h0, 1'b1, 8'd9, 1'b1, 1'b1, 32'd0};
        vecs[13] = '{1'b0, 8'd0, 32'd0,         4'h0, 1'b1, 8'd8, 1'b1, 1'b1, 32'hDEADBEEF};
        vecs[14] = '{1'b0, 8'd0, 32'd0,         4'h0, 1'b1, 8'd0, 1'b1, 1'b1, 32'd32};
        vecs[15] = '{1'b0, 8'd0, 32'd0,         4'h0, 1'b0, 8'd0, 1'b1, 1'b0, 32'd32};

        idleIn();
        rst = 1'b1;
        tick();
        tick();
        chk("reset_out", bus.mem_out, 32'd0);
        chk("reset_valid", 32'(bus.rd_valid), 32'd0);
        chk("reset_busy", 32'(bus.busy), 32'd1);
        rst = 1'b0;
        sweepLen("init_sweep");
        readAddr("init_rd0", 8'd0, 32'd0);
        readAddr("init_rd25", 8'd25, 32'd0);
        readAddr("init_rd255", 8'd255, 32'd0);

        for (int i = 0; i < 16; i++) begin
            bus.wEn    = vecs[i].wEn;
            bus.w_addr = vecs[i].wa;
            bus.data   = vecs[i].d;
            bus.w_mask = vecs[i].m;
            bus.rEn    = vecs[i].rEn;
            bus.r_addr = vecs[i].ra;
            tick();
            if (vecs[i].chk) begin
                chk($sformatf("vec%0d_valid", i), 32'(bus.rd_valid), 32'(vecs[i].ev));
                chk($sformatf("vec%0d_out", i), bus.mem_out, vecs[i].eo);
            end
        end
        idleIn();

        // Clear pulse collides with a write and a read; clr must win.
        bus.wEn    = 1'b1;
        bus.w_addr = 8'd3;
        bus.data   = 32'h5A;
        bus.w_mask = 4'hF;
        tick();
        bus.clr    = 1'b1;
        bus.w_addr = 8'd4;
        bus.data   = 32'h77;
        bus.rEn    = 1'b1;
        bus.r_addr = 8'd3;
        tick();
        chk("clr_valid", 32'(bus.rd_valid), 32'd0);
        chk("clr_busy", 32'(bus.busy), 32'd1);
        idleIn();
        sweepLen("clr_sweep");
        readAddr("clr_rd3", 8'd3, 32'd0);
        readAddr("clr_rd4", 8'd4, 32'd0);

        // Reset lands on sweep edge 100 and restarts the sweep.
        bus.clr = 1'b1;
        tick();
        bus.clr = 1'b0;
        for (int i = 0; i < 98; i++) tick();
        chk("mid_busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_busy", 32'(bus.busy), 32'd1);
        chk("rst_mid_out", bus.mem_out, 32'd0);
        sweepLen("rst_sweep");

        for (int i = 0; i < 200; i++) begin
            bus.wEn    = 1'($urandom_range(0, 1));
            bus.w_addr = 8'($urandom_range(0, 15));
            bus.data   = $urandom;
            bus.w_mask = 4'($urandom_range(0, 15));
            bus.rEn    = 1'($urandom_range(0, 1));
            bus.r_addr = ($urandom_range(0, 2) == 0) ? bus.w_addr : 8'($urandom_range(0, 15));
            tick();
        end
        idleIn();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
